// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the LC-3 general-purpose register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sweep_state_t;

  localparam int DEFAULT_DATA_W   = 16;
  localparam int DEFAULT_NUM_REGS = 8;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue reserves a destination, write-back or the clear sweep releases it.
module regfile_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic              wipe_en,
  input  logic [ADDR_W-1:0] wipe_idx,
  input  logic [ADDR_W-1:0] rd1_idx,
  input  logic [ADDR_W-1:0] rd2_idx,
  output logic              rd1_busy,
  output logic              rd2_busy
);

  logic [NUM_REGS-1:0] busy;

  // NOTE: sequential state uses non-blocking assignments so every bit samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // A new issue reserves after the older write-back to the same index.
        if (set_en && set_idx == ADDR_W'(i)) begin
          busy[i] <= 1'b1;
        end else if ((clr_en && clr_idx == ADDR_W'(i)) ||
                     (wipe_en && wipe_idx == ADDR_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  assign rd1_busy = busy[rd1_idx];
  assign rd2_busy = busy[rd2_idx];

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two async read ports, one write port, optional bypass,
// busy scoreboard and a one-entry-per-cycle clear sweep.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int   DATA_W   = DEFAULT_DATA_W,
  parameter int   NUM_REGS = DEFAULT_NUM_REGS,
  parameter bit   BYPASS   = 1'b1,
  localparam int  ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] mainBus,
  input  logic [ADDR_W-1:0] DR,
  input  logic              LD_REG,
  input  logic [ADDR_W-1:0] SR1,
  input  logic [ADDR_W-1:0] SR2,
  input  logic              ISSUE,
  input  logic [ADDR_W-1:0] ISSUE_DR,
  input  logic              CLR_REQ,
  output logic [DATA_W-1:0] SR1_OUT,
  output logic [DATA_W-1:0] SR2_OUT,
  output logic              SR1_BUSY,
  output logic              SR2_BUSY,
  output logic              READY
);

  sweep_state_t      state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              wipe_en;
  logic              idle;
  logic              wr_en;
  logic              iss_en;
  logic [DATA_W-1:0] regs [NUM_REGS];

  assign idle   = (state == IDLE);
  assign wr_en  = LD_REG && idle;
  assign iss_en = ISSUE && idle;
  assign READY  = idle;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wipe_en   = 1'b0;
    case (state)
      IDLE: begin
        if (CLR_REQ) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        wipe_en = 1'b1;
        if (cnt == '1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: the array needs a reset-to-zero, so it is built from flops rather than a RAM macro.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[DR] <= mainBus;
    end else if (wipe_en) begin
      regs[cnt] <= '0;
    end
  end

  // wr_en is already gated by IDLE, which keeps the bypass off during a sweep.
  always_comb begin
    SR1_OUT = regs[SR1];
    SR2_OUT = regs[SR2];
    if (BYPASS && wr_en && SR1 == DR) SR1_OUT = mainBus;
    if (BYPASS && wr_en && SR2 == DR) SR2_OUT = mainBus;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .set_en   (iss_en),
    .set_idx  (ISSUE_DR),
    .clr_en   (wr_en),
    .clr_idx  (DR),
    .wipe_en  (wipe_en),
    .wipe_idx (cnt),
    .rd1_idx  (SR1),
    .rd2_idx  (SR2),
    .rd1_busy (SR1_BUSY),
    .rd2_busy (SR2_BUSY)
  );

endmodule
